// File: rtl/instruction_cache_pkg.sv
// Shared cache/memory-controller definitions: fill FSM state encoding and address field widths.
package instruction_cache_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } ic_state_t;

    localparam int IC_ADDR_WIDTH  = 32;
    localparam int IC_INDEX_BITS  = 6;
    localparam int IC_OFFSET_BITS = 4;
    localparam int IC_WORD_BITS   = 32;
    localparam int IC_LINE_BITS   = 128;

endpackage

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache, one outstanding line fill at a time.
// Latency: hit returns data combinationally; miss costs request edge + memory latency + 1 cycle.
// Backpressure: Sys_rdy low freezes all state; new lookups are not accepted while a fill is pending.
module instruction_cache
    import instruction_cache_pkg::*;
#(
    parameter int ADDR_WIDTH  = IC_ADDR_WIDTH,
    parameter int INDEX_BITS  = IC_INDEX_BITS,
    parameter int OFFSET_BITS = IC_OFFSET_BITS
) (
    input  logic                    Sys_clk,
    input  logic                    Sys_rst,
    input  logic                    Sys_rdy,
    input  logic                    IFIC_en,
    input  logic [ADDR_WIDTH-1:0]   IFIC_addr,
    output logic                    ICIF_en,
    output logic [IC_WORD_BITS-1:0] ICIF_data,
    output logic                    ICMC_en,
    output logic [ADDR_WIDTH-1:0]   ICMC_addr,
    input  logic                    MCIC_en,
    input  logic [IC_LINE_BITS-1:0] MCIC_block
);

    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int LSB_BITS = OFFSET_BITS + 3;
    localparam logic [LSB_BITS-1:0] WORD_MASK = {{(OFFSET_BITS-2){1'b1}}, 5'b00000};

    ic_state_t             state_q;
    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [IC_LINE_BITS-1:0] data_q [LINES];

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic [LSB_BITS-1:0]   word_lsb;
    logic                  hit;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  fill_done;

    assign req_index = IFIC_addr[OFFSET_BITS +: INDEX_BITS];
    assign req_tag   = IFIC_addr[ADDR_WIDTH-1 -: TAG_BITS];
    // Byte offset scaled to a bit position, with the sub-word byte bits masked off.
    assign word_lsb  = {IFIC_addr[OFFSET_BITS-1:0], 3'b000} & WORD_MASK;
    assign hit       = valid_q[req_index] && (tag_q[req_index] == req_tag);

    assign ICIF_en   = IFIC_en && Sys_rdy && (state_q == IDLE) && hit;
    assign ICIF_data = data_q[req_index][word_lsb +: IC_WORD_BITS];

    // The pending fill's line is identified by the registered request, not the live fetch address.
    assign fill_index = ICMC_addr[OFFSET_BITS +: INDEX_BITS];
    assign fill_tag   = ICMC_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign fill_done  = Sys_rdy && !Sys_rst && (state_q == WAIT_MEM) && MCIC_en;

    always_ff @(posedge Sys_clk) begin
        if (Sys_rst) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            ICMC_en   <= 1'b0;
            ICMC_addr <= '0;
        end else if (Sys_rdy) begin
            case (state_q)
                IDLE: begin
                    if (IFIC_en && !hit) begin
                        ICMC_addr <= {IFIC_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                        ICMC_en   <= 1'b1;
                        state_q   <= WAIT_MEM;
                    end
                end
                WAIT_MEM: begin
                    if (MCIC_en) begin
                        valid_q[fill_index] <= 1'b1;
                        ICMC_en             <= 1'b0;
                        state_q             <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag and data storage carry no reset; only the valid bits qualify them.
    always_ff @(posedge Sys_clk) begin
        if (fill_done) begin
            tag_q[fill_index]  <= fill_tag;
            data_q[fill_index] <= MCIC_block;
        end
    end

endmodule
